// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the memory port arbiter, its two requesters (IFU, LSU) and the memory.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32
);
  // IFU read-only request/response channel
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [DATA_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_resp_err;

  // LSU read/write request/response channel
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [DATA_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [3:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_resp_err;

  // Shared memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction, variable-latency
// response with optional timeout, fixed LSU priority or round-robin arbitration.
module mem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter bit LSU_PRIO = 1'b1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wmask;
  } req_t;

  state_t            state_q, state_d;
  owner_t            owner_q;
  owner_t            last_q;
  req_t              req_q, req_sel;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ifu_win, lsu_win;
  logic              accept, resp_ok, resp_to;

  logic              ifu_rv_q, ifu_err_q;
  logic              lsu_rv_q, lsu_err_q;
  logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;

  // Contention: LSU_PRIO gives the LSU a fixed win, otherwise the requester not served last wins.
  always_comb begin
    lsu_win = bus.lsu_req_valid &&
              (!bus.ifu_req_valid || LSU_PRIO || (last_q == OWN_IFU));
    ifu_win = bus.ifu_req_valid && !lsu_win;
  end

  // Request fields captured on the handshake; the IFU only ever reads.
  always_comb begin
    req_sel = '0;
    if (lsu_win) begin
      req_sel.addr  = bus.lsu_addr;
      req_sel.wen   = bus.lsu_wen;
      req_sel.wdata = bus.lsu_wdata;
      req_sel.wmask = bus.lsu_wmask;
    end else begin
      req_sel.addr  = bus.ifu_addr;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    resp_ok = 1'b0;
    resp_to = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_win || lsu_win) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A response arriving on the timeout cycle takes precedence over the error.
        if (bus.mem_resp_valid) begin
          resp_ok = 1'b1;
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          resp_to = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
    end else if (accept) begin
      req_q   <= req_sel;
      owner_q <= lsu_win ? OWN_LSU : OWN_IFU;
      last_q  <= lsu_win ? OWN_LSU : OWN_IFU;
    end
  end

  // Response pulses last one cycle; data and error hold until that requester's next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_rv_q    <= 1'b0;
      ifu_err_q   <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rv_q    <= 1'b0;
      lsu_err_q   <= 1'b0;
      lsu_rdata_q <= '0;
    end else begin
      ifu_rv_q <= 1'b0;
      lsu_rv_q <= 1'b0;
      if (resp_ok || resp_to) begin
        if (owner_q == OWN_IFU) begin
          ifu_rv_q    <= 1'b1;
          ifu_err_q   <= resp_to;
          ifu_rdata_q <= resp_ok ? bus.mem_rdata : '0;
        end else begin
          lsu_rv_q    <= 1'b1;
          lsu_err_q   <= resp_to;
          lsu_rdata_q <= resp_ok ? bus.mem_rdata : '0;
        end
      end
    end
  end

  assign bus.ifu_req_ready  = (state_q == S_IDLE) && ifu_win;
  assign bus.lsu_req_ready  = (state_q == S_IDLE) && lsu_win;

  assign bus.mem_req_valid  = (state_q == S_REQ);
  assign bus.mem_addr       = req_q.addr;
  assign bus.mem_wen        = req_q.wen;
  assign bus.mem_wdata      = req_q.wdata;
  assign bus.mem_wmask      = req_q.wmask;

  assign bus.ifu_resp_valid = ifu_rv_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.ifu_resp_err   = ifu_err_q;
  assign bus.lsu_resp_valid = lsu_rv_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_err_q;

endmodule
